// File: rtl/alu_issue_stage.sv
// Decode/issue stage: turns RV integer ALU instructions (OP, OP-IMM, LUI, AUIPC)
// into execute-ALU controls and operands, held in one valid/ready register stage.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_funct3,
  output logic            out_invert,
  output logic [XLEN-1:0] out_operand_1,
  output logic [XLEN-1:0] out_operand_2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned SHAMT_W = (XLEN == 32) ? 5 : 6;

  // Masks over instr[31:25]: bits that must be zero for SLLI / SRLI / SRAI.
  // For right shifts bit 30 selects arithmetic and is left free.
  localparam logic [6:0] SLLI_HI_MASK = (SHAMT_W == 6) ? 7'b1111110 : 7'b1111111;
  localparam logic [6:0] SRI_HI_MASK  = (SHAMT_W == 6) ? 7'b1011110 : 7'b1011111;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic signed [11:0] imm_i12;
  logic signed [31:0] imm_u32;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_u;
  logic [5:0]        shamt;
  logic [XLEN-1:0]   shamt_ext;
  logic              unused_rs_fields;

  assign opcode    = in_instr[6:0];
  assign funct3    = in_instr[14:12];
  assign funct7    = in_instr[31:25];
  assign rd        = in_instr[11:7];
  assign imm_i12   = in_instr[31:20];
  assign imm_u32   = {in_instr[31:12], 12'b0};
  assign imm_i     = XLEN'(imm_i12);
  assign imm_u     = XLEN'(imm_u32);
  assign shamt     = (SHAMT_W == 6) ? in_instr[25:20] : {1'b0, in_instr[24:20]};
  assign shamt_ext = XLEN'(shamt);

  // Register source fields are resolved upstream; only their data arrives here.
  assign unused_rs_fields = ^in_instr[19:15];

  logic [2:0]      dec_funct3;
  logic            dec_invert;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic            dec_legal;

  // Instruction decode; illegal encodings collapse to a neutral add of zeros.
  always_comb begin
    dec_funct3 = funct3;
    dec_invert = 1'b0;
    dec_op1    = '0;
    dec_op2    = '0;
    dec_legal  = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        dec_op1 = in_rs1_data;
        dec_op2 = in_rs2_data;
        if (funct7 == 7'b0100000)
          dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        else
          dec_legal = (funct7 == 7'b0000000);
        if (funct3 == 3'b000)
          dec_invert = ~in_instr[30];
        else if (funct3 == 3'b101)
          dec_invert = in_instr[30];
      end
      OPC_OP_IMM: begin
        dec_op1 = in_rs1_data;
        dec_op2 = imm_i;
        unique case (funct3)
          3'b000: dec_invert = 1'b1;
          3'b001: begin
            dec_op2   = shamt_ext;
            dec_legal = (funct7 & SLLI_HI_MASK) == 7'b0;
          end
          3'b101: begin
            dec_op2    = shamt_ext;
            dec_invert = in_instr[30];
            dec_legal  = (funct7 & SRI_HI_MASK) == 7'b0;
          end
          default: ;
        endcase
      end
      OPC_LUI: begin
        dec_funct3 = 3'b000;
        dec_invert = 1'b1;
        dec_op2    = imm_u;
      end
      OPC_AUIPC: begin
        dec_funct3 = 3'b000;
        dec_invert = 1'b1;
        dec_op1    = in_pc;
        dec_op2    = imm_u;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_funct3 = 3'b000;
      dec_invert = 1'b1;
      dec_op1    = '0;
      dec_op2    = '0;
    end
  end

  logic capture;

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Output register; data fields only move on capture, flush wins over capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_funct3    <= 3'b000;
      out_invert    <= 1'b0;
      out_operand_1 <= '0;
      out_operand_2 <= '0;
      out_rd        <= 5'd0;
      out_rd_we     <= 1'b0;
      out_illegal   <= 1'b0;
      out_pc        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_funct3    <= dec_funct3;
      out_invert    <= dec_invert;
      out_operand_1 <= dec_op1;
      out_operand_2 <= dec_op2;
      out_rd        <= rd;
      out_rd_we     <= dec_legal && (rd != 5'd0);
      out_illegal   <= !dec_legal;
      out_pc        <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage (XLEN=32): directed literal cases plus
// randomized traffic compared every cycle against a behavioural decode model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_funct3;
  logic        out_invert;
  logic [31:0] out_operand_1;
  logic [31:0] out_operand_2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_funct3(out_funct3), .out_invert(out_invert),
    .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal),
    .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic        inv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } ent_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-class rules.
  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] rs1, input logic [31:0] rs2);
    ent_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal;
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '0;
    d.rd = ins[11:7];
    d.pc = pc;
    d.f3 = f3;
    legal = 1'b1;
    case (ins[6:0])
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        d.op1 = rs1;
        d.op2 = rs2;
        d.inv = (f3 == 3'd0) ? !ins[30] : (f3 == 3'd5) ? ins[30] : 1'b0;
      end
      7'h13: begin
        d.op1 = rs1;
        if (f3 == 3'd1) begin
          legal = (f7 == 7'h00);
          d.op2 = 32'(ins[24:20]);
        end else if (f3 == 3'd5) begin
          legal = (f7 == 7'h00) || (f7 == 7'h20);
          d.op2 = 32'(ins[24:20]);
          d.inv = ins[30];
        end else begin
          d.op2 = 32'($signed(ins) >>> 20);
          d.inv = (f3 == 3'd0);
        end
      end
      7'h37, 7'h17: begin
        d.f3  = 3'd0;
        d.inv = 1'b1;
        d.op1 = (ins[6:0] == 7'h17) ? pc : 32'd0;
        d.op2 = ins & 32'hFFFF_F000;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      d.f3 = 3'd0;
      d.inv = 1'b1;
      d.op1 = 32'd0;
      d.op2 = 32'd0;
    end
    d.ill = !legal;
    d.we  = legal && (d.rd != 5'd0);
    return d;
  endfunction

  // Behavioural model of the held entry.
  logic m_valid = 1'b0;
  ent_t m_ent   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ent   <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      m_ent   <= ref_decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("funct3", 64'(out_funct3), 64'(m_ent.f3));
      chk("invert", 64'(out_invert), 64'(m_ent.inv));
      chk("operand_1", 64'(out_operand_1), 64'(m_ent.op1));
      chk("operand_2", 64'(out_operand_2), 64'(m_ent.op2));
      chk("rd", 64'(out_rd), 64'(m_ent.rd));
      chk("rd_we", 64'(out_rd_we), 64'(m_ent.we));
      chk("illegal", 64'(out_illegal), 64'(m_ent.ill));
      chk("pc", 64'(out_pc), 64'(m_ent.pc));
    end
  end

  // Literal expectations on both the DUT and the model.
  task automatic expect_out(input string name, input logic [2:0] f3, input logic inv,
                            input logic [31:0] op1, input logic [31:0] op2,
                            input logic [4:0] rd, input logic we, input logic ill);
    chk({name, ".valid"}, 64'(out_valid), 64'd1);
    chk({name, ".funct3"}, 64'(out_funct3), 64'(f3));
    chk({name, ".invert"}, 64'(out_invert), 64'(inv));
    chk({name, ".op1"}, 64'(out_operand_1), 64'(op1));
    chk({name, ".op2"}, 64'(out_operand_2), 64'(op2));
    chk({name, ".rd"}, 64'(out_rd), 64'(rd));
    chk({name, ".rd_we"}, 64'(out_rd_we), 64'(we));
    chk({name, ".illegal"}, 64'(out_illegal), 64'(ill));
    chk({name, ".model_op2"}, 64'(m_ent.op2), 64'(op2));
    chk({name, ".model_inv"}, 64'(m_ent.inv), 64'(inv));
    chk({name, ".model_ill"}, 64'(m_ent.ill), 64'(ill));
  endtask

  // Called at posedge+2; returns at posedge+2 with the instruction captured.
  task automatic drive_one(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid    = 1'b1;
    in_instr    = ins;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    out_ready   = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  f7;
    int unsigned sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    case ($urandom_range(0, 3))
      0, 3:    f7 = 7'h00;
      1:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    if (sel <= 2) begin
      ins[6:0] = 7'h33;
      ins[31:25] = f7;
    end else if (sel <= 5) begin
      ins[6:0] = 7'h13;
      if (ins[13:12] == 2'b01) ins[31:25] = f7;
    end else if (sel == 6) begin
      ins[6:0] = 7'h37;
    end else if (sel == 7) begin
      ins[6:0] = 7'h17;
    end else if (sel == 9) begin
      ins = 32'h0;
    end
    return ins;
  endfunction

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset.
    repeat (3) @(posedge clk);
    #2;
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.data", {out_funct3, out_invert, out_rd, out_rd_we, out_illegal},  64'd0);
    chk("rst.ops", {out_operand_1, out_operand_2}, 64'd0);
    chk("rst.pc", 64'(out_pc), 64'd0);

    drive_one(32'h002081B3, 32'h0, 32'd5, 32'd3);
    expect_out("add", 3'b000, 1'b1, 32'd5, 32'd3, 5'd3, 1'b1, 1'b0);
    drive_one(32'h402081B3, 32'h4, 32'd5, 32'd3);
    expect_out("sub", 3'b000, 1'b0, 32'd5, 32'd3, 5'd3, 1'b1, 1'b0);
    drive_one(32'h40435293, 32'h8, 32'h8000_0000, 32'h0);
    expect_out("srai", 3'b101, 1'b1, 32'h8000_0000, 32'h4, 5'd5, 1'b1, 1'b0);
    drive_one(32'hFFF00093, 32'hC, 32'h0, 32'h0);
    expect_out("addi", 3'b000, 1'b1, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);
    drive_one(32'h123453B7, 32'h100, 32'hDEAD, 32'hBEEF);
    expect_out("lui", 3'b000, 1'b1, 32'h0, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
    chk("lui.pc", 64'(out_pc), 64'h100);
    drive_one(32'h12345397, 32'h100, 32'hDEAD, 32'hBEEF);
    expect_out("auipc", 3'b000, 1'b1, 32'h100, 32'h1234_5000, 5'd7, 1'b1, 1'b0);
    drive_one(32'h00000000, 32'h104, 32'h1, 32'h2);
    expect_out("zero", 3'b000, 1'b1, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    drive_one(32'h4020F1B3, 32'h108, 32'h1, 32'h2);
    expect_out("op_f7_and", 3'b000, 1'b1, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1);

    // Back-pressure: A held while B is offered, then consumed/captured together.
    drive_one(32'h002081B3, 32'h200, 32'd11, 32'd22);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_instr    = 32'h00500093;
    in_pc       = 32'h204;
    in_rs1_data = 32'd7;
    repeat (4) begin
      @(posedge clk);
      #2;
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      chk("bp.hold_op1", 64'(out_operand_1), 64'd11);
      chk("bp.hold_pc", 64'(out_pc), 64'h200);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    expect_out("bp.b", 3'b000, 1'b1, 32'd7, 32'd5, 5'd1, 1'b1, 1'b0);

    // Flush beats a simultaneous capture.
    out_ready = 1'b0;
    flush     = 1'b1;
    in_instr  = 32'h002081B3;
    @(posedge clk);
    #2;
    chk("flush.valid", 64'(out_valid), 64'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("flush.dropped", 64'(out_valid), 64'd0);

    // Asynchronous reset with a held entry.
    drive_one(32'h002081B3, 32'h300, 32'd1, 32'd1);
    out_ready = 1'b0;
    chk("areset.pre", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("areset.valid", 64'(out_valid), 64'd0);
    chk("areset.model", 64'(m_valid), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      in_instr    = rand_instr();
      in_pc       = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
